ttl_dff_bank: RTL and testbench



---
 rtl/ttl_dff_bank.sv | 124 ++++++++++++
 tb/tb_ttl_dff_bank.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ttl_dff_bank.sv
// ttl_dff_bank: WIDTH independent '74-style D flip-flops with active-low
// preset/clear, all running on one system clock. Each channel's TTL clock
// pin is sampled and edge-detected instead of being used as a clock.
// Optional macro TTL_DFF_BANK_SYNC_EN adds a two-flop synchroniser on
// TCLK, D, nPRE and nCLR (+2 CLK latency, identical on every input path).
module ttl_dff_bank #(
    parameter int               WIDTH = 2,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] TCLK,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] nPRE,
    input  logic [WIDTH-1:0] nCLR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] nQ,
    output logic [WIDTH-1:0] EDGE
);

    // Inputs as seen by the edge/override logic.
    logic [WIDTH-1:0] tclk_s, d_s, npre_s, nclr_s;

`ifdef TTL_DFF_BANK_SYNC_EN
    logic [WIDTH-1:0] tclk_q1, tclk_q2, d_q1, d_q2;
    logic [WIDTH-1:0] npre_q1, npre_q2, nclr_q1, nclr_q2;

    // Two-flop synchronisers; reset values keep the core idle (TCLK high so
    // no spurious edge, overrides released, data low).
    always_ff @(posedge CLK) begin
        if (RST) begin
            tclk_q1 <= '1;
            tclk_q2 <= '1;
            d_q1    <= '0;
            d_q2    <= '0;
            npre_q1 <= '1;
            npre_q2 <= '1;
            nclr_q1 <= '1;
            nclr_q2 <= '1;
        end else begin
            tclk_q1 <= TCLK;
            tclk_q2 <= tclk_q1;
            d_q1    <= D;
            d_q2    <= d_q1;
            npre_q1 <= nPRE;
            npre_q2 <= npre_q1;
            nclr_q1 <= nCLR;
            nclr_q2 <= nclr_q1;
        end
    end

    assign tclk_s = tclk_q2;
    assign d_s    = d_q2;
    assign npre_s = npre_q2;
    assign nclr_s = nclr_q2;
`else
    assign tclk_s = TCLK;
    assign d_s    = D;
    assign npre_s = nPRE;
    assign nclr_s = nCLR;
`endif

    logic [WIDTH-1:0] tprev_q;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] nq_q, nq_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    // Set while a channel sits in the both-low (Q=nQ=1) state, so the first
    // released cycle can restore nQ to 0.
    logic [WIDTH-1:0] inval_q, inval_d;
    logic [WIDTH-1:0] rise;

    assign rise = tclk_s & ~tprev_q;

    // Per-channel next state: overrides first, then captured edge, then hold.
    always_comb begin
        q_d     = q_q;
        nq_d    = nq_q;
        edge_d  = '0;
        inval_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!npre_s[i] && !nclr_s[i]) begin
                q_d[i]     = 1'b1;
                nq_d[i]    = 1'b1;
                inval_d[i] = 1'b1;
            end else if (!npre_s[i]) begin
                q_d[i]  = 1'b1;
                nq_d[i] = 1'b0;
            end else if (!nclr_s[i]) begin
                q_d[i]  = 1'b0;
                nq_d[i] = 1'b1;
            end else if (rise[i]) begin
                q_d[i]    = d_s[i];
                nq_d[i]   = ~d_s[i];
                edge_d[i] = 1'b1;
            end else if (inval_q[i]) begin
                // Q is already 1 from the both-low state; only nQ recovers.
                nq_d[i] = 1'b0;
            end
        end
    end

    // State register; tprev tracks TCLK every cycle, even during overrides,
    // so edges seen under an override are discarded rather than deferred.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tprev_q <= '1;
            q_q     <= INIT;
            nq_q    <= ~INIT;
            edge_q  <= '0;
            inval_q <= '0;
        end else begin
            tprev_q <= tclk_s;
            q_q     <= q_d;
            nq_q    <= nq_d;
            edge_q  <= edge_d;
            inval_q <= inval_d;
        end
    end

    assign Q    = q_q;
    assign nQ   = nq_q;
    assign EDGE = edge_q;

endmodule

// File: tb/tb_ttl_dff_bank.sv
// Directed bench for ttl_dff_bank (WIDTH=2, INIT=2'b10). Each table row is one
// CLK cycle: inputs driven before the edge, outputs expected just after it.
module tb_ttl_dff_bank;

    localparam int         W    = 2;
    localparam logic [1:0] INIT = 2'b10;

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] TCLK, D, nPRE, nCLR;
    logic [W-1:0] Q, nQ, EDGE;

    int checks   = 0;
    int failures = 0;

    ttl_dff_bank #(.WIDTH(W), .INIT(INIT)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .TCLK (TCLK),
        .D    (D),
        .nPRE (nPRE),
        .nCLR (nCLR),
        .Q    (Q),
        .nQ   (nQ),
        .EDGE (EDGE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic [1:0] tclk, d, npre, nclr;
        logic [1:0] q, nq, edg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [1:0] tclk, logic [1:0] d,
                                logic [1:0] npre, logic [1:0] nclr,
                                logic [1:0] q, logic [1:0] nq, logic [1:0] edg);
        vec_t v;
        v.rst = rst; v.tclk = tclk; v.d = d; v.npre = npre; v.nclr = nclr;
        v.q = q; v.nq = nq; v.edg = edg;
        return v;
    endfunction

    task automatic chk(string name, logic [1:0] act, logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic [1:0] tclk, logic [1:0] d,
                         logic [1:0] npre, logic [1:0] nclr);
        RST = rst; TCLK = tclk; D = d; nPRE = npre; nCLR = nclr;
        @(posedge CLK);
        #1;
    endtask

    task automatic expect3(string tag, logic [1:0] q, logic [1:0] nq, logic [1:0] edg);
        chk({tag, ".Q"},    Q,    q);
        chk({tag, ".nQ"},   nQ,   nq);
        chk({tag, ".EDGE"}, EDGE, edg);
    endtask

    initial begin
        RST = 1'b1; TCLK = 2'b11; D = 2'b00; nPRE = 2'b11; nCLR = 2'b11;
        #1;
`ifdef TTL_DFF_BANK_SYNC_EN
        // Basic capture through the synchroniser: +2 CLK versus direct build.
        drive(1, 2'b11, 2'b00, 2'b11, 2'b11);
        drive(1, 2'b11, 2'b00, 2'b11, 2'b11);
        expect3("sync_rst", 2'b10, 2'b01, 2'b00);
        for (int i = 0; i < 4; i++) drive(0, 2'b00, 2'b01, 2'b11, 2'b11);
        expect3("sync_idle", 2'b10, 2'b01, 2'b00);
        drive(0, 2'b11, 2'b01, 2'b11, 2'b11);      // edge k
        expect3("sync_k", 2'b10, 2'b01, 2'b00);
        drive(0, 2'b11, 2'b01, 2'b11, 2'b11);      // edge k+1
        expect3("sync_k1", 2'b10, 2'b01, 2'b00);
        drive(0, 2'b11, 2'b01, 2'b11, 2'b11);      // edge k+2
        expect3("sync_k2", 2'b01, 2'b10, 2'b11);
        drive(0, 2'b11, 2'b10, 2'b11, 2'b11);      // edge k+3
        expect3("sync_k3", 2'b01, 2'b10, 2'b00);
`else
        //              rst tclk   d      npre   nclr     q      nq     edge
        // reset, TCLK already high at release: no edge
        vecs.push_back(mk(1, 2'b11, 2'b00, 2'b11, 2'b11,  2'b10, 2'b01, 2'b00));
        vecs.push_back(mk(1, 2'b11, 2'b00, 2'b11, 2'b11,  2'b10, 2'b01, 2'b00));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b11, 2'b11,  2'b10, 2'b01, 2'b00));
        // basic capture on both channels, then hold TCLK high
        vecs.push_back(mk(0, 2'b00, 2'b01, 2'b11, 2'b11,  2'b10, 2'b01, 2'b00));
        vecs.push_back(mk(0, 2'b11, 2'b01, 2'b11, 2'b11,  2'b01, 2'b10, 2'b11));
        vecs.push_back(mk(0, 2'b11, 2'b10, 2'b11, 2'b11,  2'b01, 2'b10, 2'b00));
        vecs.push_back(mk(0, 2'b11, 2'b10, 2'b11, 2'b11,  2'b01, 2'b10, 2'b00));
        // clear both, then toggle only channel 0
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b11, 2'b00,  2'b00, 2'b11, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b11, 2'b11, 2'b11,  2'b01, 2'b10, 2'b01));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b11, 2'b11,  2'b01, 2'b10, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b10, 2'b11, 2'b11,  2'b00, 2'b11, 2'b01));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b11, 2'b11,  2'b00, 2'b11, 2'b00));
        // both overrides low during an edge, release with no edge
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b00,  2'b11, 2'b11, 2'b00));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b11, 2'b11,  2'b11, 2'b00, 2'b00));
        // both low again, release coinciding with a ch0 edge (edge wins)
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00,  2'b11, 2'b11, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b10, 2'b11, 2'b11,  2'b10, 2'b01, 2'b01));
        // set Q[0]=1, then 3-cycle nCLR[0] pulse spanning a TCLK[0] rise
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b11, 2'b11,  2'b10, 2'b01, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b11, 2'b11, 2'b11,  2'b11, 2'b00, 2'b01));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b11, 2'b10,  2'b10, 2'b01, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b11, 2'b11, 2'b10,  2'b10, 2'b01, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b11, 2'b11, 2'b10,  2'b10, 2'b01, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b11, 2'b11, 2'b11,  2'b10, 2'b01, 2'b00));
        // preset only on channel 0
        vecs.push_back(mk(0, 2'b01, 2'b11, 2'b10, 2'b11,  2'b11, 2'b00, 2'b00));
        // mid-run reset, then reset on a pending edge
        vecs.push_back(mk(1, 2'b00, 2'b11, 2'b11, 2'b11,  2'b10, 2'b01, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b01, 2'b11, 2'b11,  2'b10, 2'b01, 2'b00));
        vecs.push_back(mk(0, 2'b00, 2'b01, 2'b11, 2'b11,  2'b10, 2'b01, 2'b00));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b11, 2'b11,  2'b10, 2'b01, 2'b00));
        vecs.push_back(mk(0, 2'b01, 2'b01, 2'b11, 2'b11,  2'b10, 2'b01, 2'b00));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].tclk, vecs[i].d, vecs[i].npre, vecs[i].nclr);
            expect3($sformatf("v%0d", i), vecs[i].q, vecs[i].nq, vecs[i].edg);
        end

        // One-sample-wide TCLK high pulse and low gap are each enough.
        drive(0, 2'b00, 2'b00, 2'b11, 2'b11);
        expect3("pulse_lo", 2'b10, 2'b01, 2'b00);
        drive(0, 2'b11, 2'b11, 2'b11, 2'b11);
        expect3("pulse_hi", 2'b11, 2'b00, 2'b11);
        drive(0, 2'b00, 2'b00, 2'b11, 2'b11);
        expect3("gap_lo", 2'b11, 2'b00, 2'b00);
        drive(0, 2'b11, 2'b00, 2'b11, 2'b11);
        expect3("gap_hi", 2'b00, 2'b11, 2'b11);
        drive(0, 2'b11, 2'b11, 2'b11, 2'b11);
        expect3("gap_hold", 2'b00, 2'b11, 2'b00);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
